// File: rtl/div_display_mux.sv
// Display stage for the 4-bit divider: holds the last quotient/remainder/error
// and scans them as decimal digits onto a 4-digit common-anode seven-segment display.
module div_display_mux #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_error,
  input  logic [3:0] quot,
  input  logic [3:0] rem,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    MODE_BLANK,
    MODE_RESULT,
    MODE_ERROR
  } mode_t;

  mode_t         mode;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    q_hold;
  logic [3:0]    r_hold;
  logic          tc;
  logic [6:0]    nxt_seg;
  logic          nxt_dp;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Values are at most 15, so the tens digit is either blank or '1'.
  function automatic logic [6:0] tens_seg(input logic [3:0] v);
    return (v >= 4'd10) ? seg_code(4'd1) : SEG_BLANK;
  endfunction

  function automatic logic [6:0] units_seg(input logic [3:0] v);
    return seg_code((v >= 4'd10) ? v - 4'd10 : v);
  endfunction

  assign tc = (cnt == TC);

  always_comb begin
    nxt_seg = SEG_BLANK;
    nxt_dp  = 1'b1;
    case (mode)
      MODE_RESULT: begin
        case (idx)
          2'd3: nxt_seg = tens_seg(q_hold);
          2'd2: begin
            nxt_seg = units_seg(q_hold);
            nxt_dp  = 1'b0;
          end
          2'd1: nxt_seg = tens_seg(r_hold);
          default: nxt_seg = units_seg(r_hold);
        endcase
      end
      MODE_ERROR: begin
        case (idx)
          2'd3:    nxt_seg = SEG_E;
          2'd2:    nxt_seg = SEG_R;
          2'd1:    nxt_seg = SEG_R;
          default: nxt_seg = SEG_BLANK;
        endcase
      end
      default: begin
        nxt_seg = SEG_BLANK;
        nxt_dp  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      mode   <= MODE_BLANK;
      q_hold <= '0;
      r_hold <= '0;
      seg    <= '1;
      an     <= 4'b1110;
      dp     <= 1'b1;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (tc)
        idx <= idx + 2'd1;
      if (in_valid) begin
        q_hold <= quot;
        r_hold <= rem;
        mode   <= in_error ? MODE_ERROR : MODE_RESULT;
      end
      seg <= nxt_seg;
      an  <= ~(4'b0001 << idx);
      dp  <= nxt_dp;
    end
  end

endmodule

// File: tb/tb_div_display_mux.sv
// Randomized bench for div_display_mux against an arithmetic reference model
// of the scan position and the decimal digit map.
module tb_div_display_mux;

  localparam int unsigned R = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_error = 1'b0;
  logic [3:0] quot = '0;
  logic [3:0] rem = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  div_display_mux #(.REFRESH_DIV(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_error (in_error),
    .quot     (quot),
    .rem      (rem),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: edges since reset, mode (0 blank, 1 result, 2 error), held values.
  int m_k    = 0;
  int m_mode = 0;
  int m_q    = 0;
  int m_r    = 0;

  localparam logic [6:0] BLANK = 7'b1111111;

  function automatic logic [6:0] digit_code(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  function automatic logic [6:0] model_seg(input int mode, input int q, input int r, input int pos);
    int v;
    if (mode == 0) return BLANK;
    if (mode == 2) begin
      if (pos == 3) return 7'b0000110;
      if (pos == 0) return BLANK;
      return 7'b0101111;
    end
    v = (pos >= 2) ? q : r;
    if (pos % 2 == 1) return (v / 10 == 0) ? BLANK : digit_code(v / 10);
    return digit_code(v % 10);
  endfunction

  function automatic int shown_pos();
    return (m_k == 0) ? 0 : ((m_k - 1) / R) % 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [6:0] es;
    logic [3:0] ea;
    logic       ed;
    int         pos;
    if (rst) begin
      es = BLANK; ea = 4'b1110; ed = 1'b1;
      m_k = 0; m_mode = 0; m_q = 0; m_r = 0;
    end else begin
      pos = (m_k / R) % 4;
      es  = model_seg(m_mode, m_q, m_r, pos);
      ed  = (m_mode == 1 && pos == 2) ? 1'b0 : 1'b1;
      ea  = ~4'(1 << pos);
      m_k++;
      if (in_valid) begin
        m_mode = in_error ? 2 : 1;
        m_q = quot;
        m_r = rem;
      end
    end
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(es));
    check("an",  32'(an),  32'(ea));
    check("dp",  32'(dp),  32'(ed));
  endtask

  task automatic pulse(input logic [3:0] q, input logic [3:0] r, input logic e);
    in_valid = 1'b1; quot = q; rem = r; in_error = e;
    tick();
    in_valid = 1'b0; in_error = $urandom_range(0, 1);
    quot = 4'($urandom); rem = 4'($urandom);
  endtask

  task automatic wait_pos(input int d);
    int n = 0;
    while (shown_pos() != d && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("wait_pos_timeout", 32'(n), 32'(0));
  endtask

  // Expected seg per displayed digit, index 3 first.
  task automatic check_frame(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0, input logic dp2);
    logic [6:0] ex [4];
    ex = '{e0, e1, e2, e3};
    tick();
    for (int d = 3; d >= 0; d--) begin
      wait_pos(d);
      check({tag, "_seg"}, 32'(seg), 32'(ex[d]));
      check({tag, "_dp"}, 32'(dp), 32'((d == 2) ? dp2 : 1'b1));
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) tick();

    pulse(4'd3, 4'd1, 1'b0);
    check_frame("q3r1", BLANK, 7'b0110000, BLANK, 7'b1111001, 1'b0);

    pulse(4'd15, 4'd12, 1'b0);
    check_frame("q15r12", 7'b1111001, 7'b0010010, 7'b1111001, 7'b0100100, 1'b0);

    pulse(4'd7, 4'd0, 1'b1);
    check_frame("err", 7'b0000110, 7'b0101111, 7'b0101111, BLANK, 1'b1);

    // New data landing on the same edge as the digit-2 -> digit-3 step.
    begin
      int n = 0;
      while (!((m_k % R) == R - 1 && ((m_k / R) % 4) == 2) && n < 40) begin
        tick();
        n++;
      end
      if (n >= 40) check("tc_align_timeout", 32'(n), 32'(0));
    end
    pulse(4'd2, 4'd0, 1'b0);
    tick();
    check("tc_d3_an", 32'(an), 32'(4'b0111));
    check("tc_d3_seg", 32'(seg), 32'(BLANK));
    pulse(4'd9, 4'd0, 1'b0);
    tick();
    wait_pos(2);
    check("q9_d2_seg", 32'(seg), 32'(7'b0010000));
    check("q9_d2_dp", 32'(dp), 32'(1'b0));

    pulse(4'd11, 4'd5, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_an", 32'(an), 32'(4'b1110));
    check("rst_seg", 32'(seg), 32'(BLANK));
    check("rst_dp", 32'(dp), 32'(1'b1));
    for (int i = 0; i < 20; i++) tick();

    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 5) == 0);
      in_error = ($urandom_range(0, 3) == 0);
      quot     = 4'($urandom);
      rem      = 4'($urandom);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
